ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL expose parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL expose parameter TIMEOUT_US, default 1000, meaning the idle time in µs after which a partial frame is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, the 50 MHz domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PS2Clk, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port PS2Data, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port key, output, 2 bits: one-cycle key event; 00 none, 01 left, 10 right, 11 start.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL pass PS2Clk and PS2Data through 3-flop synchronisers each, reset to 1.
REQ-010 SHALL detect a falling edge when the last two synchronised PS2Clk samples are 1 then 0; that cycle is the edge cycle.
REQ-011 SHALL sample synchronised PS2Data on each edge cycle into an 11-bit frame: start, D0..D7 (LSB first), odd parity, stop.
REQ-012 SHALL keep a bit counter 0..10 that increments per edge and returns to 0 after bit 10 or after any abort.
REQ-013 SHALL, at bit 0, abort silently without pulsing frame_err if the sampled bit is 1, keeping the counter at 0.
REQ-014 SHALL, at bit 10, accept the byte only if the parity over D0..D7 plus the parity bit is odd and stop = 1; otherwise pulse frame_err and clear the decoder state to IDLE.
REQ-015 SHALL assert the internal byte_valid one cycle after the bit-10 edge cycle; key SHALL be asserted one cycle after byte_valid (latency 2 clk from the stop-bit edge cycle).
REQ-016 SHALL clear the timeout counter on every edge cycle; when the counter is non-zero and the count reaches CLK_HZ/1_000_000*TIMEOUT_US, it SHALL reset the counter, pulse frame_err, and clear the decoder state to IDLE.
REQ-017 SHALL give an edge priority over timeout when both occur in the same cycle; the timeout counter SHALL be cleared and not fire.
REQ-018 SHALL run a decoder state machine with states IDLE, EXT, BRK and EXT_BRK, stepping once per accepted byte.
REQ-019 SHALL, in IDLE, go to EXT on E0 and to BRK on F0; on 29 (space) it SHALL make start and stay in IDLE; on any other byte it SHALL stay in IDLE.
REQ-020 SHALL, in EXT, go to EXT_BRK on F0; on 6B it SHALL make left, on 74 make right, on other bytes ignore; in all non-F0 cases it SHALL go to IDLE.
REQ-021 SHALL, in BRK, release start on 29, ignore any other byte, and go to IDLE.
REQ-022 SHALL, in EXT_BRK, release left on 6B, release right on 74, ignore any other byte, and go to IDLE.
REQ-023 SHALL hold a flag per key, set on make and cleared on release; a make SHALL emit a key pulse only if that key's flag was clear, so typematic repeats are suppressed.
REQ-024 SHALL keep key at 00 in every cycle except the single pulse cycle; frame_err SHALL be a single-cycle pulse.
REQ-025 SHALL emit at most one key event per accepted byte, so simultaneous events are impossible by construction.

Reset
REQ-026 SHALL, while rst = 0, asynchronously force key = 00, frame_err = 0, bit counter = 0, timeout counter = 0, shift register = 0, state = IDLE, all held flags = 0, and synchroniser flops = 1.
REQ-027 SHALL discard any partial frame on reset asserted mid-frame; the first edge after release SHALL be treated as bit 0.

Verification
REQ-028 SHALL cover: valid frames E0, 6B -> key = 01 for exactly 1 cycle, 2 cycles after the second frame's stop edge.
REQ-029 SHALL cover: frames 29, 29, 29 (typematic) -> exactly one key = 11 pulse; then F0, 29, 29 -> a second 11 pulse.
REQ-030 SHALL cover: E0, F0, 74, then E0, 74 -> no pulse for the break sequence, then key = 10 once.
REQ-031 SHALL cover: frame 6B with a bad parity bit -> frame_err = 1 for 1 cycle, key stays 00, state = IDLE.
REQ-032 SHALL cover: 5 bits of a frame then no edges for TIMEOUT_US -> frame_err pulse; a following valid 29 frame -> key = 11.
REQ-033 SHALL cover: rst = 0 pulsed after 6 bits of E0 -> all outputs 0; a following full E0, 6B -> key = 01.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder.
// Emits one-cycle left/right/start events; discarded frames pulse frame_err.
module ps2_key_decoder #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [1:0] key,
  output logic       frame_err
);

  localparam int LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW    = $clog2(LIMIT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic [2:0]    c_sync;
  logic [2:0]    d_sync;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_valid;
  logic [7:0]    byte_q;
  state_t        state;
  logic          held_l;
  logic          held_r;
  logic          held_s;

  logic ps2_fall;
  logic ps2_bit;
  logic frame_ok;
  logic tout;
  logic abort;

  assign ps2_fall = c_sync[2] & ~c_sync[1];
  assign ps2_bit  = d_sync[2];
  assign frame_ok = (^{shreg, par_bit}) & ps2_bit;
  assign tout     = (bit_cnt != 4'd0) && !ps2_fall
                  && (tcnt == TW'(LIMIT));
  assign abort    = tout
                  || (ps2_fall && bit_cnt == 4'd10 && !frame_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync     <= 3'b111;
      d_sync     <= 3'b111;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      byte_q     <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      c_sync     <= {c_sync[1:0], PS2Clk};
      d_sync     <= {d_sync[1:0], PS2Data};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (ps2_fall) begin
        tcnt <= '0;
        unique case (1'b1)
          bit_cnt == 4'd0: begin
            if (!ps2_bit) bit_cnt <= 4'd1;
          end
          bit_cnt == 4'd9: begin
            par_bit <= ps2_bit;
            bit_cnt <= 4'd10;
          end
          bit_cnt == 4'd10: begin
            bit_cnt <= 4'd0;
            if (frame_ok) begin
              byte_valid <= 1'b1;
              byte_q     <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            shreg   <= {ps2_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (tout) begin
        tcnt      <= '0;
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  // A make only pulses when the key was not already held (typematic filter)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      key    <= 2'b00;
      held_l <= 1'b0;
      held_r <= 1'b0;
      held_s <= 1'b0;
    end else begin
      key <= 2'b00;
      if (abort) begin
        state <= IDLE;
      end else if (byte_valid) begin
        unique case (state)
          IDLE: begin
            if (byte_q == 8'hE0) state <= EXT;
            if (byte_q == 8'hF0) state <= BRK;
            if (byte_q == 8'h29) begin
              if (!held_s) key <= 2'b11;
              held_s <= 1'b1;
            end
          end
          EXT: begin
            state <= (byte_q == 8'hF0) ? EXT_BRK : IDLE;
            if (byte_q == 8'h6B) begin
              if (!held_l) key <= 2'b01;
              held_l <= 1'b1;
            end
            if (byte_q == 8'h74) begin
              if (!held_r) key <= 2'b10;
              held_r <= 1'b1;
            end
          end
          BRK: begin
            state <= IDLE;
            if (byte_q == 8'h29) held_s <= 1'b0;
          end
          EXT_BRK: begin
            state <= IDLE;
            if (byte_q == 8'h6B) held_l <= 1'b0;
            if (byte_q == 8'h74) held_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scan-code vector table
// plus latency, parity, timeout, bit-0 abort and reset sequences.
module tb_ps2_key_decoder;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       PS2Clk;
  logic       PS2Data;
  logic [1:0] key;
  logic       frame_err;

  ps2_key_decoder #(
    .CLK_HZ    (1_000_000),
    .TIMEOUT_US(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PS2Clk   (PS2Clk),
    .PS2Data  (PS2Data),
    .key      (key),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nvec = 0;
  int         nbad = 0;
  int         n_key, n_err, long_key, long_err;
  int         key_cyc, stop_cyc;
  logic [1:0] last_key, prev_key = 2'b00;
  logic       prev_err = 1'b0;

  always @(negedge clk) begin
    if (key != 2'b00) begin
      n_key++;
      last_key = key;
      key_cyc  = cyc;
      if (prev_key != 2'b00) long_key++;
    end
    if (frame_err) begin
      n_err++;
      if (prev_err) long_err++;
    end
    prev_key = key;
    prev_err = frame_err;
  end

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic [1:0] k;
    int         np;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic [1:0] k, input int np);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.k = k; v.np = np;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    n_key = 0; n_err = 0; long_key = 0; long_err = 0;
    last_key = 2'b00; key_cyc = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad = 1'b0,
                            input int nbits = 11);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      repeat (H) @(negedge clk);
      PS2Data = fr[i];
      repeat (H) @(negedge clk);
      PS2Clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge clk);
      PS2Clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    PS2Data = 1'b1;
  endtask

  task automatic release_all();
    send_frame(8'hF0); send_frame(8'h29);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bj;
    vt[0]  = mk(2, 8'hE0, 8'h6B, 8'h00, 2'b01, 1);
    vt[1]  = mk(2, 8'hE0, 8'h6B, 8'h00, 2'b01, 0);
    vt[2]  = mk(3, 8'hE0, 8'hF0, 8'h6B, 2'b00, 0);
    vt[3]  = mk(3, 8'h29, 8'h29, 8'h29, 2'b11, 1);
    vt[4]  = mk(3, 8'hF0, 8'h29, 8'h29, 2'b11, 1);
    vt[5]  = mk(3, 8'hE0, 8'hF0, 8'h74, 2'b00, 0);
    vt[6]  = mk(2, 8'hE0, 8'h74, 8'h00, 2'b10, 1);
    vt[7]  = mk(2, 8'hE0, 8'h74, 8'h00, 2'b10, 0);
    vt[8]  = mk(3, 8'hE0, 8'hF0, 8'h74, 2'b00, 0);
    vt[9]  = mk(1, 8'h1C, 8'h00, 8'h00, 2'b00, 0);
    vt[10] = mk(3, 8'hE0, 8'h1C, 8'h74, 2'b00, 0);
    vt[11] = mk(3, 8'hF0, 8'h1C, 8'h6B, 2'b00, 0);
    vt[12] = mk(2, 8'hF0, 8'h29, 8'h00, 2'b00, 0);
    vt[13] = mk(1, 8'h29, 8'h00, 8'h00, 2'b11, 1);
    vt[14] = mk(2, 8'hE0, 8'h6B, 8'h00, 2'b01, 1);
    vt[15] = mk(2, 8'hF0, 8'h29, 8'h00, 2'b00, 0);

    rst = 1'b0; PS2Clk = 1'b1; PS2Data = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    check("reset key", int'(key), 0);
    check("reset frame_err", int'(frame_err), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // latency from stop-bit edge to key pulse
    clr();
    send_frame(8'hE0);
    send_frame(8'h6B);
    repeat (10) @(negedge clk);
    check("lat pulses", n_key, 1);
    check("lat key", int'(last_key), 1);
    check("lat cycles", key_cyc - stop_cyc, 4);
    check("lat width", long_key, 0);
    release_all();

    foreach (vt[i]) begin
      clr();
      for (int j = 0; j < vt[i].n; j++) begin
        bj = (j == 0) ? vt[i].b0 : (j == 1) ? vt[i].b1 : vt[i].b2;
        send_frame(bj);
      end
      repeat (10) @(negedge clk);
      check($sformatf("v%0d pulses", i), n_key, vt[i].np);
      if (vt[i].np > 0)
        check($sformatf("v%0d key", i), int'(last_key), int'(vt[i].k));
      check($sformatf("v%0d err", i), n_err, 0);
      check($sformatf("v%0d width", i), long_key, 0);
    end

    // bad parity after E0 must drop back to IDLE, so 74 is ignored
    release_all();
    clr();
    send_frame(8'hE0);
    send_frame(8'h6B, 1'b1);
    repeat (10) @(negedge clk);
    check("par err", n_err, 1);
    check("par err width", long_err, 0);
    check("par key", n_key, 0);
    send_frame(8'h74);
    repeat (10) @(negedge clk);
    check("par idle", n_key, 0);

    // timeout on a partial frame
    clr();
    send_frame(8'h1C, 1'b0, 5);
    repeat (150) @(negedge clk);
    check("tout err", n_err, 1);
    check("tout err width", long_err, 0);
    send_frame(8'h29);
    repeat (10) @(negedge clk);
    check("tout pulses", n_key, 1);
    check("tout key", int'(last_key), 3);
    check("tout err after", n_err, 1);

    // start bit sampled as 1 aborts silently
    clr();
    repeat (H) @(negedge clk);
    PS2Data = 1'b1;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b0;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b1;
    send_frame(8'hF0);
    send_frame(8'h29);
    send_frame(8'h29);
    repeat (10) @(negedge clk);
    check("abort err", n_err, 0);
    check("abort pulses", n_key, 1);
    check("abort key", int'(last_key), 3);

    // reset in the middle of a frame
    clr();
    send_frame(8'hE0, 1'b0, 6);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst key", int'(key), 0);
    check("midrst frame_err", int'(frame_err), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hE0);
    send_frame(8'h6B);
    repeat (10) @(negedge clk);
    check("midrst pulses", n_key, 1);
    check("midrst key out", int'(last_key), 1);
    check("midrst err", n_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
